ir_nec_encode: RTL and testbench



---
 rtl/ir_nec_pkg.sv | 46 ++++
 rtl/ir_nec_encode_carrier.sv | 35 +++
 rtl/ir_nec_encode.sv | 116 +++++++++++
 tb/tb_ir_nec_encode.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ir_nec_pkg.sv
// Shared types and timing constants for the NEC IR transmitter.
// All durations are in NEC time units (562.5 us at the default UNIT_CYC).
package ir_nec_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_REP_SPACE  = 3'd3,
    S_BIT_MARK   = 3'd4,
    S_BIT_SPACE  = 3'd5,
    S_STOP_MARK  = 3'd6,
    S_GAP        = 3'd7
  } nec_state_t;

  localparam int LEAD_MARK_U  = 16;
  localparam int LEAD_SPACE_U = 8;
  localparam int REP_SPACE_U  = 4;
  localparam int BIT_MARK_U   = 1;
  localparam int ZERO_SPACE_U = 1;
  localparam int ONE_SPACE_U  = 3;
  localparam int STOP_U       = 1;

  localparam int UNIT_CYC_DEF    = 28125;
  localparam int CAR_DIV_DEF     = 1316;
  localparam int CAR_HIGH_DEF    = 658;
  localparam int FRAME_UNITS_DEF = 192;

  // Units a state lasts; GAP and IDLE are not unit-bounded and return 1.
  function automatic logic [4:0] state_units(input nec_state_t s, input logic bit_val);
    case (s)
      S_LEAD_MARK:  state_units = 5'(LEAD_MARK_U);
      S_LEAD_SPACE: state_units = 5'(LEAD_SPACE_U);
      S_REP_SPACE:  state_units = 5'(REP_SPACE_U);
      S_BIT_MARK:   state_units = 5'(BIT_MARK_U);
      S_BIT_SPACE:  state_units = bit_val ? 5'(ONE_SPACE_U) : 5'(ZERO_SPACE_U);
      S_STOP_MARK:  state_units = 5'(STOP_U);
      default:      state_units = 5'd1;
    endcase
  endfunction

  function automatic logic is_mark(input nec_state_t s);
    is_mark = (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
  endfunction

endpackage

// File: rtl/ir_nec_encode_carrier.sv
// 38 kHz carrier generator; enable/restart describe the coming cycle so the
// carrier output is registered and aligned with the mark envelope.
module ir_carrier_gen #(
  parameter int CAR_DIV  = 1316,
  parameter int CAR_HIGH = 658
) (
  input  logic CLOCK_50,
  input  logic s_rst_n,
  input  logic enable,
  input  logic restart,
  output logic carrier
);

  logic [10:0] car_cnt;
  logic [10:0] car_cnt_nxt;

  // Restart forces phase 0 so every burst opens with a full high phase.
  always_comb begin
    car_cnt_nxt = '0;
    if (enable && !restart) begin
      car_cnt_nxt = (car_cnt == 11'(CAR_DIV - 1)) ? 11'd0 : car_cnt + 11'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge s_rst_n) begin
    if (!s_rst_n) begin
      car_cnt <= '0;
      carrier <= 1'b0;
    end else begin
      car_cnt <= car_cnt_nxt;
      carrier <= enable && (car_cnt_nxt < 11'(CAR_HIGH));
    end
  end

endmodule

// File: rtl/ir_nec_encode.sv
// NEC infrared frame transmitter: modulated LED drive plus an active-low
// envelope usable as a demodulated receiver input for loopback.
module ir_nec_encode
  import ir_nec_pkg::*;
#(
  parameter int UNIT_CYC    = UNIT_CYC_DEF,
  parameter int CAR_DIV     = CAR_DIV_DEF,
  parameter int CAR_HIGH    = CAR_HIGH_DEF,
  parameter int FRAME_UNITS = FRAME_UNITS_DEF
) (
  input  logic        CLOCK_50,
  input  logic        s_rst_n,
  input  logic [31:0] tx_data,
  input  logic        tx_repeat,
  input  logic        tx_req,
  output logic        tx_rdy,
  output logic        tx_done,
  output logic        ir_tx,
  output logic        ir_env_n,
  output logic [2:0]  dbg_state
);

  localparam int UW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
  localparam int FW = $clog2(FRAME_UNITS + 1);

  // Handshake: a request is taken in any cycle where tx_req && tx_rdy; the
  // frame word and repeat flag are captured on that edge, tx_rdy drops the
  // next cycle, and requests while tx_rdy=0 are dropped, never queued.
  nec_state_t    state, state_nxt;
  logic [UW-1:0] unit_cnt;
  logic [4:0]    u_cnt;
  logic [FW-1:0] frame_cnt;
  logic [4:0]    bit_idx;
  logic [31:0]   data_q;
  logic          rep_q;

  logic accept, unit_end, st_done, state_chg, mark_nxt, done_nxt;

  assign accept    = tx_rdy && tx_req;
  assign unit_end  = (unit_cnt == UW'(UNIT_CYC - 1));
  assign st_done   = unit_end && (u_cnt == state_units(state, data_q[bit_idx]) - 5'd1);
  assign state_chg = (state_nxt != state);
  assign mark_nxt  = is_mark(state_nxt);
  // Look one cycle ahead so the registered pulse lands on the last stop cycle.
  assign done_nxt  = (state == S_STOP_MARK) && (u_cnt == 5'(STOP_U - 1)) &&
                     (unit_cnt == UW'(UNIT_CYC - 2));
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:       if (accept)  state_nxt = S_LEAD_MARK;
      S_LEAD_MARK:  if (st_done) state_nxt = rep_q ? S_REP_SPACE : S_LEAD_SPACE;
      S_LEAD_SPACE: if (st_done) state_nxt = S_BIT_MARK;
      S_REP_SPACE:  if (st_done) state_nxt = S_STOP_MARK;
      S_BIT_MARK:   if (st_done) state_nxt = S_BIT_SPACE;
      S_BIT_SPACE:  if (st_done) state_nxt = (bit_idx == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
      S_STOP_MARK:  if (st_done) state_nxt = S_GAP;
      S_GAP:        if (unit_end && (frame_cnt >= FW'(FRAME_UNITS - 1))) state_nxt = S_IDLE;
      default:      state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge s_rst_n) begin
    if (!s_rst_n) begin
      state     <= S_IDLE;
      unit_cnt  <= '0;
      u_cnt     <= '0;
      frame_cnt <= '0;
      bit_idx   <= '0;
      data_q    <= '0;
      rep_q     <= 1'b0;
      tx_rdy    <= 1'b1;
      tx_done   <= 1'b0;
      ir_env_n  <= 1'b1;
    end else begin
      state <= state_nxt;

      if (state == S_IDLE || state_chg || unit_end) unit_cnt <= '0;
      else                                          unit_cnt <= unit_cnt + UW'(1);

      // GAP is timed by the frame counter, so the per-state unit count stops there.
      if (state == S_IDLE || state_chg)           u_cnt <= '0;
      else if (unit_end && state != S_GAP)        u_cnt <= u_cnt + 5'd1;

      if (accept)
        frame_cnt <= '0;
      else if (state != S_IDLE && unit_end && frame_cnt != FW'(FRAME_UNITS))
        frame_cnt <= frame_cnt + FW'(1);

      if (accept)                               bit_idx <= '0;
      else if (state == S_BIT_SPACE && st_done) bit_idx <= bit_idx + 5'd1;

      if (accept) begin
        data_q <= tx_data;
        rep_q  <= tx_repeat;
      end

      tx_rdy   <= (state_nxt == S_IDLE);
      tx_done  <= done_nxt;
      ir_env_n <= !mark_nxt;
    end
  end

  ir_carrier_gen #(
    .CAR_DIV  (CAR_DIV),
    .CAR_HIGH (CAR_HIGH)
  ) u_carrier (
    .CLOCK_50 (CLOCK_50),
    .s_rst_n  (s_rst_n),
    .enable   (mark_nxt),
    .restart  (mark_nxt && state_chg),
    .carrier  (ir_tx)
  );

endmodule

// File: tb/tb_ir_nec_encode.sv
// Bench for ir_nec_encode: per-cycle waveform against a segment-level NEC
// model, plus independent decoding of the envelope's run lengths.
module tb_ir_nec_encode;
  import ir_nec_pkg::*;

  localparam int UNIT_CYC    = 10;
  localparam int CAR_DIV     = 4;
  localparam int CAR_HIGH    = 2;
  localparam int FRAME_UNITS = 192;
  localparam int FRAME_CYC   = UNIT_CYC * FRAME_UNITS;

  logic        CLOCK_50 = 1'b0;
  logic        s_rst_n  = 1'b0;
  logic [31:0] tx_data  = '0;
  logic        tx_repeat = 1'b0;
  logic        tx_req   = 1'b0;
  logic        tx_rdy, tx_done, ir_tx, ir_env_n;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_errs   = 0;

  // {tx_rdy, tx_done, ir_env_n, ir_tx} per cycle, starting with the first mark cycle
  logic [3:0] exp_q[$];
  int         env_log[$];

  // clock / reset block
  always #10 CLOCK_50 = ~CLOCK_50;

  initial begin
    #5ms;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  ir_nec_encode #(
    .UNIT_CYC    (UNIT_CYC),
    .CAR_DIV     (CAR_DIV),
    .CAR_HIGH    (CAR_HIGH),
    .FRAME_UNITS (FRAME_UNITS)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .s_rst_n   (s_rst_n),
    .tx_data   (tx_data),
    .tx_repeat (tx_repeat),
    .tx_req    (tx_req),
    .tx_rdy    (tx_rdy),
    .tx_done   (tx_done),
    .ir_tx     (ir_tx),
    .ir_env_n  (ir_env_n),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // reference model: a frame is a list of (mark/space, units) segments
  task automatic push_seg(input bit mark, input int units);
    for (int k = 0; k < units * UNIT_CYC; k++)
      exp_q.push_back({1'b0, 1'b0, ~mark, mark && ((k % CAR_DIV) < CAR_HIGH)});
  endtask

  task automatic build_expected(input logic [31:0] d, input logic rep);
    logic [3:0] last;
    exp_q.delete();
    push_seg(1'b1, 16);
    if (rep) push_seg(1'b0, 4);
    else begin
      push_seg(1'b0, 8);
      for (int i = 0; i < 32; i++) begin
        push_seg(1'b1, 1);
        push_seg(1'b0, d[i] ? 3 : 1);
      end
    end
    push_seg(1'b1, 1);
    last = exp_q[exp_q.size() - 1];
    exp_q[exp_q.size() - 1] = last | 4'b0100;
    while (exp_q.size() < FRAME_CYC) exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1010);
  endtask

  task automatic decode_env(input logic [31:0] d, input logic rep, input string name);
    int runs[$];
    int lvl, len, bad_sp, bad_mk;
    logic [31:0] word;
    lvl = env_log[0];
    len = 0;
    foreach (env_log[i]) begin
      if (env_log[i] == lvl) len++;
      else begin
        runs.push_back(len);
        lvl = env_log[i];
        len = 1;
      end
    end
    runs.push_back(len);
    check({name, "_first_lvl"}, 32'(env_log[0]), 32'd0);
    check({name, "_runs"}, 32'(runs.size()), rep ? 32'd4 : 32'd68);
    if (runs.size() == (rep ? 4 : 68)) begin
      check({name, "_lead_mark"}, 32'(runs[0]), 32'(16 * UNIT_CYC));
      check({name, "_lead_space"}, 32'(runs[1]), rep ? 32'(4 * UNIT_CYC) : 32'(8 * UNIT_CYC));
      check({name, "_stop"}, 32'(runs[runs.size() - 2]), 32'(UNIT_CYC));
      if (!rep) begin
        word = '0;
        bad_sp = 0;
        bad_mk = 0;
        for (int i = 0; i < 32; i++) begin
          if (runs[2 + 2 * i] != UNIT_CYC) bad_mk++;
          if (runs[3 + 2 * i] != UNIT_CYC && runs[3 + 2 * i] != 3 * UNIT_CYC) bad_sp++;
          word[i] = (runs[3 + 2 * i] >= 2 * UNIT_CYC);
        end
        check({name, "_word"}, word, d);
        check({name, "_bit_marks"}, 32'(bad_mk), 32'd0);
        check({name, "_bit_spaces"}, 32'(bad_sp), 32'd0);
      end
    end
  endtask

  // driver: one request, capture the whole frame, optional stray requests
  task automatic send_frame(input logic [31:0] d, input logic rep, input bit glitch,
                            input string name);
    int wave_errs, first_bad, done_cnt, rdy_at, post_errs;
    logic [3:0] obs, exp;
    wave_errs = 0; first_bad = -1; done_cnt = 0; rdy_at = -1; post_errs = 0;
    build_expected(d, rep);
    env_log.delete();
    @(negedge CLOCK_50);
    tx_data   = d;
    tx_repeat = rep;
    tx_req    = 1'b1;
    @(posedge CLOCK_50);
    for (int t = 0; exp_q.size() > 0; t++) begin
      @(negedge CLOCK_50);
      obs = {tx_rdy, tx_done, ir_env_n, ir_tx};
      exp = exp_q.pop_front();
      if (obs !== exp) begin
        wave_errs++;
        if (first_bad < 0) first_bad = t;
      end
      if (tx_done) done_cnt++;
      if (tx_rdy && rdy_at < 0) rdy_at = t;
      env_log.push_back(int'(ir_env_n));
      tx_req = glitch && ((t >= 100 && t < 103) || t == FRAME_CYC - 1);
      if (tx_req) begin
        tx_data   = $urandom;
        tx_repeat = 1'($urandom_range(0, 1));
      end
    end
    tx_req = 1'b0;
    if (first_bad >= 0) $display("note %s: first waveform difference at cycle %0d", name, first_bad);
    for (int t = 0; t < 40; t++) begin
      @(negedge CLOCK_50);
      if (!(tx_rdy === 1'b1 && ir_env_n === 1'b1 && ir_tx === 1'b0 && tx_done === 1'b0))
        post_errs++;
    end
    check({name, "_wave"}, 32'(wave_errs), 32'd0);
    check({name, "_done_cnt"}, 32'(done_cnt), 32'd1);
    check({name, "_rdy_at"}, 32'(rdy_at), 32'(FRAME_CYC));
    check({name, "_post_idle"}, 32'(post_errs), 32'd0);
    decode_env(d, rep, name);
  endtask

  task automatic reset_mid_frame();
    @(negedge CLOCK_50);
    tx_data   = $urandom;
    tx_repeat = 1'b0;
    tx_req    = 1'b1;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    tx_req = 1'b0;
    // cycle 245 is offset 5 into bit 0's mark: carrier phase high
    repeat (245) @(negedge CLOCK_50);
    check("pre_rst_ir_tx", 32'(ir_tx), 32'd1);
    check("pre_rst_env_n", 32'(ir_env_n), 32'd0);
    #3 s_rst_n = 1'b0;
    #1;
    check("async_rst_ir_tx", 32'(ir_tx), 32'd0);
    check("async_rst_env_n", 32'(ir_env_n), 32'd1);
    check("async_rst_rdy", 32'(tx_rdy), 32'd1);
    repeat (3) @(negedge CLOCK_50);
    s_rst_n = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    check("post_rst_rdy", 32'(tx_rdy), 32'd1);
    check("post_rst_state", 32'(dbg_state), 32'(S_IDLE));
    check("post_rst_env_n", 32'(ir_env_n), 32'd1);
  endtask

  initial begin
    int idle_errs, idle_done;
    logic [31:0] d;
    logic r;
    idle_errs = 0;
    idle_done = 0;
    repeat (3) @(negedge CLOCK_50);
    check("rst_rdy", 32'(tx_rdy), 32'd1);
    check("rst_done", 32'(tx_done), 32'd0);
    check("rst_ir_tx", 32'(ir_tx), 32'd0);
    check("rst_env_n", 32'(ir_env_n), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(S_IDLE));
    s_rst_n = 1'b1;
    for (int t = 0; t < 100; t++) begin
      @(negedge CLOCK_50);
      if (!(tx_rdy === 1'b1 && ir_env_n === 1'b1 && ir_tx === 1'b0)) idle_errs++;
      if (tx_done !== 1'b0) idle_done++;
    end
    check("idle_outputs", 32'(idle_errs), 32'd0);
    check("idle_done", 32'(idle_done), 32'd0);

    send_frame(32'hBF40_FF00, 1'b0, 1'b0, "bf40ff00");
    send_frame(32'hDEAD_BEEF, 1'b1, 1'b0, "repeat");
    send_frame($urandom, 1'b0, 1'b1, "stray_req");
    for (int i = 0; i < 3; i++) begin
      d = $urandom;
      r = ($urandom_range(0, 3) == 0);
      send_frame(d, r, 1'b0, $sformatf("rand%0d", i));
    end
    send_frame(32'hFFFF_FFFF, 1'b0, 1'b0, "all_ones");
    send_frame(32'h0000_0000, 1'b0, 1'b0, "all_zeros");
    reset_mid_frame();
    send_frame($urandom, 1'b0, 1'b0, "after_rst");

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
